countdown_mux: RTL and testbench

Parametrised multi-digit countdown timer with a multiplexed seven-segment display driver and a timed alarm beeper. It is the generalised successor of the fixed two-digit countdown: digit count, tick rate, scan rate, beep length and segment polarity are parameters, and it adds preset load, start/pause control and status outputs. It sits between the board clock/buttons and the display and buzzer pins.

---
 rtl/countdown_pkg.sv | 29 ++
 rtl/bcd_to_7seg.sv | 33 +++
 rtl/countdown_mux.sv | 188 ++++++++++++++++++
 tb/tb_countdown_mux.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared encodings for the countdown/display slice: FSM states, the
// active-high seven-segment patterns and the preset clamp helper.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // Segment order {dp,g,f,e,d,c,b,a}, lit = 1.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment pattern, decimal point off.
// Non-BCD codes blank the digit; SEG_ACTIVE_LOW inverts for common-anode parts.
module bcd_to_7seg
    import countdown_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    output logic [7:0] pattern
);

    logic [7:0] active_high;

    always_comb begin
        active_high = SEG_BLANK;
        case (digit)
            4'd0: active_high = SEG_0;
            4'd1: active_high = SEG_1;
            4'd2: active_high = SEG_2;
            4'd3: active_high = SEG_3;
            4'd4: active_high = SEG_4;
            4'd5: active_high = SEG_5;
            4'd6: active_high = SEG_6;
            4'd7: active_high = SEG_7;
            4'd8: active_high = SEG_8;
            4'd9: active_high = SEG_9;
            default: active_high = SEG_BLANK;
        endcase
    end

    assign pattern = (SEG_ACTIVE_LOW != 0) ? ~active_high : active_high;

endmodule

// File: rtl/countdown_mux.sv
// Multi-digit BCD countdown timer with run/pause control, timed alarm beeper
// and a multiplexed seven-segment display scanner. All outputs are registered.
module countdown_mux
    import countdown_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int TICK_DIV       = 50_000_000,
    parameter int SCAN_DIV       = 50_000,
    parameter int BEEP_TICKS     = 3,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  start,
    output logic [DIGITS-1:0]     seg,
    output logic [7:0]            bs,
    output logic                  beep,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic [1:0]            fsm_state
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_TICKS - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [7:0]    BS_RESET   = (SEG_ACTIVE_LOW != 0) ? ~SEG_0 : SEG_0;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   count_dec;
    logic [CW-1:0]   preset_clamped;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            tick;
    logic            running_q, done_q, beep_q;

    logic [SW-1:0]   scan_cnt_q;
    logic [IW-1:0]   idx_q;
    logic [DIGITS-1:0] seg_q;
    logic [7:0]      bs_q, bs_d;
    logic [3:0]      scan_digit;

    // BCD decrement: a digit borrows from the next only when it is zero.
    logic [DIGITS-1:0] borrow;
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] d;
        assign d = count_q[4*g +: 4];
        assign count_dec[4*g +: 4] = borrow[g] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
        assign preset_clamped[4*g +: 4] = clamp_digit(preset[4*g +: 4]);
        if (g < DIGITS - 1) begin : g_borrow
            assign borrow[g+1] = borrow[g] && (d == 4'd0);
        end
    end

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        bcnt_d  = bcnt_q;
        if (load) begin
            // load overrides everything, including a coincident start
            state_d = ST_IDLE;
            count_d = preset_clamped;
            presc_d = '0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (count_q != '0)) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick && (count_q == CW'(1))) begin
                        state_d = ST_ALARM;
                        count_d = '0;
                        presc_d = '0;
                        bcnt_d  = '0;
                    end else begin
                        if (tick) begin
                            count_d = count_dec;
                        end
                        if (start) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ALARM: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (bcnt_q == BEEP_LAST) begin
                            state_d = ST_IDLE;
                            count_d = '0;
                            bcnt_d  = '0;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they move with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            presc_q   <= '0;
            bcnt_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            beep_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            presc_q   <= presc_d;
            bcnt_q    <= bcnt_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_ALARM);
            beep_q    <= (state_d == ST_ALARM);
        end
    end

    assign scan_digit = count_q[idx_q*4 +: 4];

    bcd_to_7seg #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_decode (
        .digit  (scan_digit),
        .pattern(bs_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= DIGITS'(1);
            bs_q       <= BS_RESET;
        end else begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_q <= '0;
                idx_q      <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
            seg_q <= DIGITS'(1) << idx_q;
            bs_q  <= bs_d;
        end
    end

    assign seg       = seg_q;
    assign bs        = bs_q;
    assign beep      = beep_q;
    assign count     = count_q;
    assign running   = running_q;
    assign done      = done_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_countdown_mux.sv
// Directed bench for countdown_mux: countdown, pause, priority, clamp,
// display scan and asynchronous reset, with a queue of expected counts.
module tb_countdown_mux;

    localparam int DIGITS = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [7:0]  preset;
    logic        start;
    logic [1:0]  seg;
    logic [7:0]  bs;
    logic        beep;
    logic [7:0]  count;
    logic        running;
    logic        done;
    logic [1:0]  fsm_state;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    countdown_mux #(
        .DIGITS(DIGITS),
        .TICK_DIV(4),
        .SCAN_DIV(2),
        .BEEP_TICKS(2),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .preset   (preset),
        .start    (start),
        .seg      (seg),
        .bs       (bs),
        .beep     (beep),
        .count    (count),
        .running  (running),
        .done     (done),
        .fsm_state(fsm_state)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic do_load(input logic [7:0] v);
        preset = v;
        load   = 1'b1;
        cyc();
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_count_change(input int budget, output int gap);
        logic [7:0] prev;
        prev = count;
        gap  = 0;
        do begin
            cyc();
            gap++;
        end while (count === prev && gap < budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int n;
        logic held;
        logic [1:0] s0, exp_seg;
        logic [7:0] exp_bs;

        reset  = 1'b1;
        load   = 1'b0;
        start  = 1'b0;
        preset = 8'h00;
        repeat (2) cyc();
        check("rst_count", count, 8'h00);
        check("rst_seg", seg, 2'b01);
        check("rst_bs", bs, 8'hC0);
        check("rst_beep", beep, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        cyc();

        // full countdown from 12
        do_load(8'h12);
        check("cd_loaded", count, 8'h12);
        do_start();
        check("cd_running", running, 1'b1);
        for (int v = 11; v >= 0; v--) exp_q.push_back(to_bcd(v));
        while (exp_q.size() > 0) begin
            wait_count_change(10, gap);
            check("cd_gap", gap, 4);
            check("cd_count", count, exp_q.pop_front());
        end
        check("cd_done", done, 1'b1);
        check("cd_beep", beep, 1'b1);
        check("cd_not_running", running, 1'b0);
        n = 0;
        while (beep === 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check("beep_len", n, 8);
        check("after_alarm_state", fsm_state, 2'd0);
        check("after_alarm_count", count, 8'h00);
        check("after_alarm_done", done, 1'b0);

        // pause and resume
        do_load(8'h05);
        do_start();
        repeat (3) cyc();
        check("pause_pre_tick", count, 8'h05);
        cyc();
        check("pause_first_tick", count, 8'h04);
        cyc();
        do_start();
        check("pause_state", fsm_state, 2'd2);
        check("pause_running", running, 1'b0);
        held = 1'b1;
        repeat (20) begin
            cyc();
            if (count !== 8'h04) held = 1'b0;
        end
        check("pause_hold", held, 1'b1);
        exp_q.push_back(8'h03);
        do_start();
        check("resume_running", running, 1'b1);
        wait_count_change(10, gap);
        check("resume_gap", gap, 2);
        check("resume_count", count, exp_q.pop_front());

        // load priority
        do_load(8'h30);
        check("load_run_count", count, 8'h30);
        check("load_run_state", fsm_state, 2'd0);
        check("load_run_running", running, 1'b0);
        preset = 8'h25;
        load   = 1'b1;
        start  = 1'b1;
        cyc();
        load   = 1'b0;
        start  = 1'b0;
        check("load_start_running", running, 1'b0);
        check("load_start_state", fsm_state, 2'd0);
        check("load_start_count", count, 8'h25);
        repeat (8) cyc();
        check("load_start_hold", count, 8'h25);

        do_load(8'h01);
        do_start();
        wait_count_change(10, gap);
        check("alarm_entry_beep", beep, 1'b1);
        check("alarm_entry_done", done, 1'b1);
        do_load(8'h07);
        check("alarm_load_beep", beep, 1'b0);
        check("alarm_load_done", done, 1'b0);
        check("alarm_load_count", count, 8'h07);

        // clamp and zero start
        do_load(8'hA5);
        check("clamp_a5", count, 8'h95);
        do_load(8'hFB);
        check("clamp_fb", count, 8'h99);
        do_load(8'h00);
        do_start();
        check("zero_start_running", running, 1'b0);
        check("zero_start_state", fsm_state, 2'd0);
        repeat (6) cyc();
        check("zero_start_hold", running, 1'b0);

        // display scan with count 47
        do_load(8'h47);
        repeat (4) cyc();
        s0 = seg;
        n  = 0;
        do begin
            cyc();
            n++;
        end while (seg === s0 && n < 5);
        check("scan_edge_seen", (seg !== s0), 1'b1);
        s0 = seg;
        for (int k = 0; k < 8; k++) begin
            exp_seg = (((k / 2) % 2) == 0) ? s0 : ~s0;
            exp_bs  = (exp_seg == 2'b01) ? ~seg7(4'h7) : ~seg7(4'h4);
            check("scan_seg", seg, exp_seg);
            check("scan_bs", bs, exp_bs);
            cyc();
        end

        // asynchronous reset mid-run
        do_load(8'h12);
        do_start();
        repeat (6) cyc();
        check("mid_run_count", count, 8'h11);
        #3 reset = 1'b1;
        #1;
        check("async_rst_count", count, 8'h00);
        check("async_rst_running", running, 1'b0);
        check("async_rst_seg", seg, 2'b01);
        check("async_rst_bs", bs, 8'hC0);
        check("async_rst_state", fsm_state, 2'd0);
        #2 reset = 1'b0;
        cyc();

        // asynchronous reset during alarm cuts the beep
        do_load(8'h01);
        do_start();
        wait_count_change(10, gap);
        check("alarm2_beep", beep, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_beep", beep, 1'b0);
        check("async_rst_done", done, 1'b0);
        #2 reset = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
